// File: rtl/spi_target_if.sv
// Byte-stream handshake between the SPI target and its local consumer/producer.
// The slave modport is the SPI target side; master is the local logic side.
interface spi_target_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_ready;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;

  modport slave  (output rx_valid, rx_data, tx_ready, input  rx_ready, tx_valid, tx_data);
  modport master (input  rx_valid, rx_data, tx_ready, output rx_ready, tx_valid, tx_data);
endinterface

// File: rtl/spi_target.sv
// SPI mode-0 target, oversampled by clk: synchronized pins, byte shifter,
// single tx holding register and a small rx FIFO with sticky error flags.
module spi_target #(
  parameter int RX_LGDEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         spi_clk,
  input  logic         spi_cs,
  input  logic         spi_mosi,
  output logic         spi_miso,
  spi_target_if.slave  bus,
  output logic         rx_overflow,
  output logic         tx_underrun,
  input  logic         flags_clr
);
  localparam int DEPTH = 1 << RX_LGDEPTH;
  localparam logic [RX_LGDEPTH:0]   FULL = (RX_LGDEPTH+1)'(DEPTH);
  localparam logic [RX_LGDEPTH:0]   CONE = (RX_LGDEPTH+1)'(1);
  localparam logic [RX_LGDEPTH-1:0] PONE = RX_LGDEPTH'(1);
  localparam logic [0:0] IDLE = 1'b0, ACTIVE = 1'b1;

  logic [1:0] clk_s, cs_s, mosi_s;
  logic       clk_h, cs_h;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s  <= 2'b00;
      cs_s   <= 2'b11;
      mosi_s <= 2'b00;
      clk_h  <= 1'b0;
      cs_h   <= 1'b1;
    end else begin
      clk_s  <= {clk_s[0], spi_clk};
      cs_s   <= {cs_s[0], spi_cs};
      mosi_s <= {mosi_s[0], spi_mosi};
      clk_h  <= clk_s[1];
      cs_h   <= cs_s[1];
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  assign sclk_rise = clk_s[1] & ~clk_h;
  assign sclk_fall = ~clk_s[1] & clk_h;
  assign cs_fall   = ~cs_s[1] & cs_h;
  assign cs_rise   = cs_s[1] & ~cs_h;

  logic [0:0] state;
  logic [2:0] bit_cnt;
  logic [7:0] sh_in, sh_out, byte_in, hold_data;
  logic       hold_full, tx_ready_q, active, start, push, push_ok, pop, load, hold_nxt;

  assign active  = (state == ACTIVE);
  assign byte_in = {sh_in[6:0], mosi_s[1]};
  // A byte boundary is the cs fall, or the fall that follows the 8th rise (counter wrapped to 0).
  assign start   = ((state == IDLE) & cs_fall) | (active & ~cs_rise & sclk_fall & (bit_cnt == 3'd0));
  assign push    = active & ~cs_rise & sclk_rise & (bit_cnt == 3'd7);
  assign load    = bus.tx_valid & tx_ready_q;
  assign hold_nxt = load | (hold_full & ~start);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      sh_in   <= 8'h00;
      sh_out  <= 8'h00;
    end else begin
      if (state == IDLE) begin
        if (cs_fall) begin
          state   <= ACTIVE;
          bit_cnt <= 3'd0;
        end
      end else if (cs_rise) begin
        state   <= IDLE;
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        sh_in   <= byte_in;
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (start)                 sh_out <= hold_full ? hold_data : 8'hFF;
      else if (active & sclk_fall) sh_out <= {sh_out[6:0], 1'b0};
    end
  end

  assign spi_miso = active & sh_out[7];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full  <= 1'b0;
      hold_data  <= 8'h00;
      tx_ready_q <= 1'b1;
    end else begin
      if (load) hold_data <= bus.tx_data;
      hold_full  <= hold_nxt;
      tx_ready_q <= ~hold_nxt;
    end
  end

  assign bus.tx_ready = tx_ready_q;

  logic [7:0]            mem [DEPTH];
  logic [RX_LGDEPTH-1:0] wptr, rptr;
  logic [RX_LGDEPTH:0]   cnt;

  assign bus.rx_valid = (cnt != '0);
  assign bus.rx_data  = mem[rptr];
  assign pop          = bus.rx_valid & bus.rx_ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok      = push & ((cnt != FULL) | pop);

  always_ff @(posedge clk) begin
    if (push_ok) mem[wptr] <= byte_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok) wptr <= wptr + PONE;
      if (pop)     rptr <= rptr + PONE;
      if (push_ok & ~pop)      cnt <= cnt + CONE;
      else if (pop & ~push_ok) cnt <= cnt - CONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_overflow <= 1'b0;
      tx_underrun <= 1'b0;
    end else if (flags_clr) begin
      rx_overflow <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      if (push & ~push_ok)    rx_overflow <= 1'b1;
      if (start & ~hold_full) tx_underrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: SPI phases of 8 clk cycles, inputs driven on clk falling edges.
module tb_spi_target;
  localparam int HP = 80;

  logic clk = 1'b0;
  logic reset, spi_clk, spi_cs, spi_mosi, spi_miso, rx_overflow, tx_underrun, flags_clr;
  int   errors = 0;
  int   checks = 0;

  spi_target_if bus();

  spi_target #(.RX_LGDEPTH(2)) dut (
    .clk(clk), .reset(reset), .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .bus(bus), .rx_overflow(rx_overflow), .tx_underrun(tx_underrun),
    .flags_clr(flags_clr)
  );

  always #5 clk = ~clk;

  task automatic spi_bits(input logic [7:0] d, input int n, input bit pop_at_push,
                          output logic [7:0] miso, output logic vb, output logic va,
                          output logic uf, output logic [7:0] popped);
    miso = 8'h00; vb = 1'b0; va = 1'b0; uf = 1'b0; popped = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = d[7-i];
      #HP;
      miso = {miso[6:0], spi_miso};
      spi_clk = 1'b1;
      if (i == 7) begin
        #20;
        vb = bus.rx_valid;
        popped = bus.rx_data;
        if (pop_at_push) bus.rx_ready = 1'b1;
        #10;
        bus.rx_ready = 1'b0;
        va = bus.rx_valid;
        uf = tx_underrun;
        #(HP-30);
      end else begin
        #HP;
      end
      spi_clk = 1'b0;
    end
    #HP;
  endtask

  task automatic tx_load(input logic [7:0] d);
    bus.tx_valid = 1'b1;
    bus.tx_data  = d;
    #10;
    bus.tx_valid = 1'b0;
  endtask

  task automatic pop_byte(output logic [7:0] d);
    d = bus.rx_data;
    bus.rx_ready = 1'b1;
    #10;
    bus.rx_ready = 1'b0;
  endtask

  task automatic clear_flags();
    flags_clr = 1'b1;
    #10;
    flags_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #20;
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b exp 0", bus.rx_valid); end
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b exp 1", bus.tx_ready); end
    checks++; if (spi_miso !== 1'b0) begin errors++; $display("FAIL reset_miso got %b exp 0", spi_miso); end
    checks++; if ({rx_overflow, tx_underrun} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {rx_overflow, tx_underrun}); end
    reset = 1'b0;
    #20;
  endtask

  task automatic test_basic();
    logic [7:0] m, p, d;
    logic vb, va, uf;
    tx_load(8'hA5);
    checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL basic_tx_ready_after_load got %b exp 0", bus.tx_ready); end
    spi_cs = 1'b0; #HP;
    spi_bits(8'h3C, 8, 1'b0, m, vb, va, uf, p);
    checks++; if (m !== 8'hA5) begin errors++; $display("FAIL basic_miso got %h exp a5", m); end
    checks++; if (vb !== 1'b0) begin errors++; $display("FAIL basic_rx_valid_early got %b exp 0", vb); end
    checks++; if (va !== 1'b1) begin errors++; $display("FAIL basic_rx_valid_latency got %b exp 1", va); end
    checks++; if (uf !== 1'b0) begin errors++; $display("FAIL basic_underrun got %b exp 0", uf); end
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL basic_tx_ready_after_use got %b exp 1", bus.tx_ready); end
    checks++; if (bus.rx_data !== 8'h3C) begin errors++; $display("FAIL basic_rx_data got %h exp 3c", bus.rx_data); end
    pop_byte(d);
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL basic_empty got %b exp 0", bus.rx_valid); end
    spi_cs = 1'b1; #HP;
    clear_flags();
  endtask

  task automatic test_underrun();
    logic [7:0] m, p, d;
    logic vb, va, uf;
    spi_cs = 1'b0; #HP;
    spi_bits(8'h5A, 8, 1'b0, m, vb, va, uf, p);
    checks++; if (m !== 8'hFF) begin errors++; $display("FAIL underrun_miso got %h exp ff", m); end
    checks++; if (uf !== 1'b1) begin errors++; $display("FAIL underrun_flag got %b exp 1", uf); end
    pop_byte(d);
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL underrun_rx_data got %h exp 5a", d); end
    spi_cs = 1'b1; #HP;
    clear_flags();
    checks++; if (tx_underrun !== 1'b0) begin errors++; $display("FAIL underrun_clear got %b exp 0", tx_underrun); end
  endtask

  task automatic test_overflow();
    logic [7:0] m, p, d;
    logic vb, va, uf;
    spi_cs = 1'b0; #HP;
    for (int k = 1; k <= 5; k++) begin
      spi_bits(8'(k), 8, 1'b0, m, vb, va, uf, p);
      if (k == 4) begin
        checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL ovf_early got %b exp 0", rx_overflow); end
      end
    end
    checks++; if (rx_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b exp 1", rx_overflow); end
    spi_cs = 1'b1; #HP;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (bus.rx_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid_%0d got %b exp 1", k, bus.rx_valid); end
      pop_byte(d);
      checks++; if (d !== 8'(k)) begin errors++; $display("FAIL ovf_data_%0d got %h exp %h", k, d, 8'(k)); end
    end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL ovf_drained got %b exp 0", bus.rx_valid); end
    clear_flags();
    checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b exp 0", rx_overflow); end
  endtask

  task automatic test_full_pop();
    logic [7:0] m, p, d;
    logic vb, va, uf;
    spi_cs = 1'b0; #HP;
    for (int k = 0; k < 4; k++) spi_bits(8'h11 + 8'(k), 8, 1'b0, m, vb, va, uf, p);
    spi_bits(8'h15, 8, 1'b1, m, vb, va, uf, p);
    checks++; if (p !== 8'h11) begin errors++; $display("FAIL fullpop_popped got %h exp 11", p); end
    checks++; if (rx_overflow !== 1'b0) begin errors++; $display("FAIL fullpop_ovf got %b exp 0", rx_overflow); end
    spi_cs = 1'b1; #HP;
    for (int k = 2; k <= 5; k++) begin
      pop_byte(d);
      checks++; if (d !== 8'h10 + 8'(k)) begin errors++; $display("FAIL fullpop_data got %h exp %h", d, 8'h10 + 8'(k)); end
    end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL fullpop_drained got %b exp 0", bus.rx_valid); end
    clear_flags();
  endtask

  task automatic test_abort();
    logic [7:0] m, p, d;
    logic vb, va, uf;
    spi_cs = 1'b0; #HP;
    spi_bits(8'hF0, 5, 1'b0, m, vb, va, uf, p);
    spi_cs = 1'b1; #HP;
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL abort_no_push got %b exp 0", bus.rx_valid); end
    spi_cs = 1'b0; #HP;
    spi_bits(8'h81, 8, 1'b0, m, vb, va, uf, p);
    spi_cs = 1'b1; #HP;
    pop_byte(d);
    checks++; if (d !== 8'h81) begin errors++; $display("FAIL abort_data got %h exp 81", d); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL abort_single got %b exp 0", bus.rx_valid); end
    clear_flags();
  endtask

  task automatic test_reset_mid();
    logic [7:0] m, p, d;
    logic vb, va, uf;
    spi_cs = 1'b0; #HP;
    spi_bits(8'h21, 8, 1'b0, m, vb, va, uf, p);
    spi_bits(8'h22, 8, 1'b0, m, vb, va, uf, p);
    tx_load(8'hC3);
    checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL rstmid_tx_ready_pre got %b exp 0", bus.tx_ready); end
    spi_bits(8'hFF, 3, 1'b0, m, vb, va, uf, p);
    reset = 1'b1; spi_cs = 1'b1; spi_clk = 1'b0;
    #1;
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rx_valid got %b exp 0", bus.rx_valid); end
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_tx_ready got %b exp 1", bus.tx_ready); end
    #19;
    reset = 1'b0;
    #HP;
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_stale got %b exp 0", bus.rx_valid); end
    tx_load(8'h5E);
    spi_cs = 1'b0; #HP;
    spi_bits(8'h77, 8, 1'b0, m, vb, va, uf, p);
    spi_cs = 1'b1; #HP;
    checks++; if (m !== 8'h5E) begin errors++; $display("FAIL rstmid_miso got %h exp 5e", m); end
    pop_byte(d);
    checks++; if (d !== 8'h77) begin errors++; $display("FAIL rstmid_data got %h exp 77", d); end
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_single got %b exp 0", bus.rx_valid); end
  endtask

  initial begin
    reset = 1'b1; spi_clk = 1'b0; spi_cs = 1'b1; spi_mosi = 1'b0; flags_clr = 1'b0;
    bus.rx_ready = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = 8'h00;
    test_reset();
    test_basic();
    test_underrun();
    test_overflow();
    test_full_pop();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/spi_target.md
SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 SHALL have parameter RX_LGDEPTH, default 2, meaning the log2 of the receive FIFO depth (4 entries).
REQ-002 SHALL have port clk, input, 1, the single system clock; all logic is rising-edge clocked.
REQ-003 SHALL have port reset, input, 1, the asynchronous active-high reset.
REQ-004 SHALL have port spi_clk, input, 1, the serial clock from the external SPI controller (mode 0), asynchronous to clk.
REQ-005 SHALL have port spi_cs, input, 1, the active-low chip select, asynchronous to clk.
REQ-006 SHALL have port spi_mosi, input, 1, the controller-to-target serial data, MSB first.
REQ-007 SHALL have port spi_miso, output, 1, the target-to-controller serial data, MSB first.
REQ-008 SHALL have port rx_valid, output, 1, indicating that the FIFO head byte is available.
REQ-009 SHALL have port rx_data, output, 8, the FIFO head byte, valid only while rx_valid is high.
REQ-010 SHALL have port rx_ready, input, 1, the consumer pop; a pop occurs when rx_valid && rx_ready.
REQ-011 SHALL have port tx_valid, input, 1, offering tx_data for the next outgoing byte.
REQ-012 SHALL have port tx_data, input, 8, the next byte to shift out.
REQ-013 SHALL have port tx_ready, output, 1, indicating that the tx holding register is empty; a load occurs when tx_valid && tx_ready.
REQ-014 SHALL have port rx_overflow, output, 1, a sticky flag set when a received byte is dropped.
REQ-015 SHALL have port tx_underrun, output, 1, a sticky flag set when a byte starts without tx data.
REQ-016 SHALL have port flags_clr, input, 1, which clears both sticky flags.

Function
REQ-017 SHALL pass spi_clk, spi_cs and spi_mosi each through a 2-flop synchronizer before use, followed by one history flop for edge detection; the pin-to-detect latency is therefore 3 clk cycles.
REQ-018 SHALL require each spi_clk phase to last at least 4 clk cycles, and the first spi_clk rise to follow the spi_cs fall by at least 4 clk cycles; behaviour outside these limits is undefined.
REQ-019 SHALL use a two-state FSM: IDLE while synchronized cs is high, and ACTIVE while it is low; the FSM enters ACTIVE on a detected cs fall and returns to IDLE on a detected cs rise.
REQ-020 SHALL, on entry to ACTIVE and after every 8th detected falling edge, start a byte: bit counter := 0; the shift-out register loads the holding register if it is full (holding then empties), otherwise loads 8'hFF and sets tx_underrun.
REQ-021 SHALL drive spi_miso from the MSB of the shift-out register while ACTIVE, shifting left by one bit on each detected spi_clk fall; spi_miso SHALL be 0 in IDLE.
REQ-022 SHALL, on each detected spi_clk rise in ACTIVE, shift the synchronized mosi into the LSB of the shift-in register and increment the 3-bit bit counter, which wraps 7->0.
REQ-023 SHALL, on the rise that completes bit 8, push the byte into the FIFO; rx_valid SHALL rise the next clk cycle if the FIFO was empty.
REQ-024 SHALL drop the byte and set rx_overflow when the FIFO is full at push time; a same-cycle push and pop on a full FIFO SHALL both succeed, leaving the count unchanged.
REQ-025 SHALL implement the FIFO with RX_LGDEPTH-bit read and write pointers that wrap modulo depth, plus an RX_LGDEPTH+1-bit count; rx_data SHALL be the head entry, combinational from storage.
REQ-026 SHALL, on a cs rise mid-byte, discard the partial shift-in byte with no push and no flag, zero the bit counter, and leave the holding register intact.
REQ-027 SHALL give flags_clr priority over a set in the same cycle; both flags SHALL then read 0 on the next cycle.
REQ-028 SHALL accept a tx load in the same cycle that the holding register is consumed only if tx_ready was high; tx_ready SHALL be registered and low for the cycle after a load.

Reset
REQ-029 SHALL, while reset is high, immediately force: FSM=IDLE, spi_miso=0, rx_valid=0, FIFO count and pointers=0, tx_ready=1, holding empty, rx_overflow=0, tx_underrun=0, synchronizers=idle values (cs=1, clk=0).
REQ-030 SHALL abandon any in-progress byte on reset, with no push; a new frame SHALL require a fresh cs fall after reset deasserts.

Verification
REQ-031 SHALL pass this scenario: load tx 8'hA5, cs low, clock in 8'h3C -> miso bits 1,0,1,0,0,1,0,1; rx_data=8'h3C; rx_valid 1 cycle after the 8th detected rise; tx_underrun=0.
REQ-032 SHALL pass this scenario: no tx load, one byte transferred -> miso carries 8'hFF and tx_underrun=1; flags_clr then -> tx_underrun=0.
REQ-033 SHALL pass this scenario: 5 bytes 01..05 sent with rx_ready=0 -> FIFO holds 01..04, byte 05 is dropped, rx_overflow=1; pops return 01,02,03,04 in order.
REQ-034 SHALL pass this scenario: FIFO full with rx_ready=1 held while the 5th byte completes -> no overflow, and the bytes drain in order.
REQ-035 SHALL pass this scenario: cs rises after 5 bits, then a new frame sends 8'h81 -> exactly one byte, 8'h81, is received.
REQ-036 SHALL pass this scenario: reset asserted mid-byte with the FIFO holding 2 entries -> rx_valid=0 and tx_ready=1 immediately; no stale data follows.
